// File: rtl/display_scheduler.sv
// display_scheduler: rotates data pages onto the 7-seg display and grants a timed overlay channel
module display_scheduler #(
    parameter int NSRC = 4,
    parameter int DWELL_CYCLES = 100_000_000,
    parameter int HOLD_CYCLES = 50_000_000,
    localparam int IW = $clog2(NSRC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NSRC*16-1:0] src_data_i,
    input  logic [NSRC-1:0]    src_valid_i,
    input  logic               auto_en_i,
    input  logic               btn_next_i,
    input  logic               ovl_req_i,
    input  logic [15:0]        ovl_data_i,
    output logic               ovl_ack_o,
    output logic               ovl_active_o,
    output logic [15:0]        disp_data_o,
    output logic [IW-1:0]      page_idx_o
);
    localparam int DW = $clog2(DWELL_CYCLES);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic {ROTATE, OVERLAY} state_t;

    state_t        state_q;
    logic [IW-1:0] page_q;
    logic [15:0]   disp_q;
    logic [15:0]   ovl_buf_q;
    logic          ack_q;
    logic          active_q;
    logic          btn_q;
    logic [DW-1:0] dwell_q;
    logic [HW-1:0] hold_q;

    logic [IW-1:0] page_d;
    logic [IW-1:0] idx;
    logic          found;
    logic [15:0]   cur_page;
    logic          advance;
    logic          hold_done;

    // nearest valid page after the current one, searching forward with wrap
    always_comb begin
        page_d = page_q;
        found = 1'b0;
        idx = '0;
        for (int k = 1; k < NSRC; k++) begin
            idx = IW'((int'(page_q) + k) % NSRC);
            if (!found && src_valid_i[idx]) begin
                page_d = idx;
                found = 1'b1;
            end
        end
    end

    assign cur_page  = src_valid_i[page_q] ? src_data_i[{page_q, 4'b0000} +: 16] : 16'h0000;
    assign advance   = (btn_next_i & ~btn_q)
                     | (auto_en_i && dwell_q == DW'(DWELL_CYCLES - 1))
                     | (!src_valid_i[page_q] && found);
    assign hold_done = hold_q == HW'(HOLD_CYCLES - 1);

    // page rotation / overlay state machine with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ROTATE;
            page_q    <= '0;
            disp_q    <= 16'h0000;
            ovl_buf_q <= 16'h0000;
            ack_q     <= 1'b0;
            active_q  <= 1'b0;
            btn_q     <= 1'b0;
            dwell_q   <= '0;
            hold_q    <= '0;
        end else begin
            btn_q <= btn_next_i;
            if (state_q == ROTATE) begin
                if (advance) page_q <= page_d;
                dwell_q <= (advance || !auto_en_i) ? '0 : dwell_q + 1'b1;
                if (ovl_req_i) begin
                    ack_q     <= 1'b1;
                    ovl_buf_q <= ovl_data_i;
                    disp_q    <= ovl_data_i;
                    active_q  <= 1'b1;
                    hold_q    <= '0;
                    state_q   <= OVERLAY;
                end else begin
                    ack_q  <= 1'b0;
                    disp_q <= cur_page;
                end
            end else begin
                ack_q  <= 1'b0;
                hold_q <= hold_q + 1'b1;
                disp_q <= ovl_buf_q;
                if (hold_done) begin
                    state_q  <= ROTATE;
                    active_q <= 1'b0;
                    disp_q   <= cur_page;
                end
            end
        end
    end

    assign ovl_ack_o    = ack_q;
    assign ovl_active_o = active_q;
    assign disp_data_o  = disp_q;
    assign page_idx_o   = page_q;
endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed stimulus with a cycle-stamped expectation queue checked by a monitor
module tb_display_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] src_data;
    logic [3:0]  src_valid;
    logic        auto_en, btn, req, ack, act;
    logic [15:0] odata, disp;
    logic [1:0]  page;

    display_scheduler #(.NSRC(4), .DWELL_CYCLES(8), .HOLD_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .src_data_i(src_data), .src_valid_i(src_valid),
        .auto_en_i(auto_en), .btn_next_i(btn), .ovl_req_i(req), .ovl_data_i(odata),
        .ovl_ack_o(ack), .ovl_active_o(act), .disp_data_o(disp), .page_idx_o(page)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [15:0] d;
        logic [1:0]  p;
        logic        k;
        logic        a;
        string       nm;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    task automatic expect_in(input int n, input logic [15:0] d, input logic [1:0] p,
                             input logic k, input logic a, input string nm);
        exp_t e;
        e.at = cyc + n; e.d = d; e.p = p; e.k = k; e.a = a; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        @(negedge clk);
        #2 rst_n = 1'b0;
        step(2);
    endtask

    task automatic press(input logic [1:0] p_new, input logic [15:0] d_old, input logic [15:0] d_new);
        expect_in(1, d_old, p_new, 0, 0, "btn_page");
        expect_in(2, d_new, p_new, 0, 0, "btn_data");
        btn = 1'b1;
        step(1);
        btn = 1'b0;
        step(2);
    endtask

    // monitor: compare every expectation whose cycle has come due
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            while (q.size() > 0 && q[0].at <= cyc) begin
                e = q.pop_front();
                total++;
                if ({disp, page, ack, act} !== {e.d, e.p, e.k, e.a} || e.at != cyc) begin
                    bad++;
                    $display("FAIL %s cyc=%0d: got disp=%h page=%0d ack=%b act=%b, want disp=%h page=%0d ack=%b act=%b (due %0d)",
                             e.nm, cyc, disp, page, ack, act, e.d, e.p, e.k, e.a, e.at);
                end
            end
        end
    end

    initial begin
        src_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        src_valid = 4'hF; auto_en = 1'b1; btn = 1'b0; req = 1'b0; odata = 16'h0000;
        // reset values and auto rotation
        step(2);
        expect_in(1, 16'h0000, 0, 0, 0, "reset_vals");
        step(1);
        expect_in(1,  16'h1111, 0, 0, 0, "auto_p0_first");
        expect_in(8,  16'h1111, 1, 0, 0, "auto_p1_idx");
        expect_in(9,  16'h2222, 1, 0, 0, "auto_p1_data");
        expect_in(16, 16'h2222, 2, 0, 0, "auto_p2_idx");
        expect_in(17, 16'h3333, 2, 0, 0, "auto_p2_data");
        expect_in(25, 16'h4444, 3, 0, 0, "auto_p3_data");
        expect_in(32, 16'h4444, 0, 0, 0, "auto_wrap_idx");
        expect_in(33, 16'h1111, 0, 0, 0, "auto_wrap_data");
        rst_n = 1'b1;
        step(34);
        // skipping invalid pages
        src_valid = 4'b1010; auto_en = 1'b0;
        do_reset;
        expect_in(1, 16'h0000, 1, 0, 0, "skip_p0_idx");
        expect_in(2, 16'h2222, 1, 0, 0, "skip_p0_data");
        rst_n = 1'b1;
        step(2);
        press(3, 16'h2222, 16'h4444);
        press(1, 16'h4444, 16'h2222);
        press(3, 16'h2222, 16'h4444);
        src_valid = 4'b0000;
        expect_in(1, 16'h0000, 3, 0, 0, "none_valid");
        expect_in(3, 16'h0000, 3, 0, 0, "none_valid_hold");
        step(3);
        // held button advances once
        src_valid = 4'hF; btn = 1'b1;
        expect_in(1,  16'h4444, 0, 0, 0, "held_btn_idx");
        expect_in(2,  16'h1111, 0, 0, 0, "held_btn_data");
        expect_in(20, 16'h1111, 0, 0, 0, "held_btn_once");
        step(20);
        btn = 1'b0;
        expect_in(2, 16'h1111, 0, 0, 0, "btn_release");
        step(2);
        // overlay handshake with dwell freeze and ignored button
        auto_en = 1'b1;
        do_reset;
        expect_in(1,  16'h1111, 0, 0, 0, "ovl_pre");
        expect_in(3,  16'h1111, 0, 0, 0, "ovl_pre_last");
        expect_in(4,  16'hBEEF, 0, 1, 1, "ovl_ack");
        expect_in(5,  16'hBEEF, 0, 0, 1, "ovl_ack_drop");
        expect_in(7,  16'hBEEF, 0, 0, 1, "ovl_last");
        expect_in(8,  16'h1111, 0, 0, 0, "ovl_exit");
        expect_in(11, 16'h1111, 0, 0, 0, "ovl_dwell_resume");
        expect_in(12, 16'h1111, 1, 0, 0, "ovl_dwell_expire");
        expect_in(13, 16'h2222, 1, 0, 0, "ovl_next_data");
        rst_n = 1'b1;
        step(3);
        req = 1'b1; odata = 16'hBEEF;
        step(1);
        req = 1'b0;
        step(1);
        btn = 1'b1;
        step(1);
        btn = 1'b0;
        step(8);
        // overlay on dwell expiry, request held through exit
        do_reset;
        expect_in(7,  16'h1111, 0, 0, 0, "sim_pre");
        expect_in(8,  16'hCAFE, 1, 1, 1, "sim_ack_adv");
        expect_in(9,  16'hCAFE, 1, 0, 1, "sim_ovl");
        expect_in(11, 16'hCAFE, 1, 0, 1, "sim_ovl_last");
        expect_in(12, 16'h2222, 1, 0, 0, "sim_gap");
        expect_in(13, 16'hD00D, 1, 1, 1, "sim_reack");
        expect_in(14, 16'hD00D, 1, 0, 1, "sim_ovl2");
        expect_in(17, 16'h2222, 1, 0, 0, "sim_exit2");
        rst_n = 1'b1;
        step(7);
        req = 1'b1; odata = 16'hCAFE;
        step(5);
        odata = 16'hD00D;
        step(1);
        req = 1'b0;
        step(4);
        // asynchronous reset mid-overlay, pending request re-acked
        req = 1'b1; odata = 16'h1234;
        expect_in(1, 16'h1234, 1, 1, 1, "ar_ack");
        step(1);
        req = 1'b0;
        expect_in(1, 16'h1234, 1, 0, 1, "ar_ovl");
        step(1);
        @(posedge clk);
        #2;
        req = 1'b1;
        expect_in(0, 16'h0000, 0, 0, 0, "async_rst");
        rst_n = 1'b0;
        @(negedge clk);
        expect_in(1, 16'h0000, 0, 0, 0, "rst_hold");
        step(1);
        expect_in(1, 16'h1234, 0, 1, 1, "reack_after_rst");
        rst_n = 1'b1;
        step(1);
        req = 1'b0;
        expect_in(1, 16'h1234, 0, 0, 1, "reack_ovl");
        step(2);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover: %0d expectations never checked, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
